fir_tap_accum: RTL and testbench

- Sequential complex accumulator sitting directly downstream of the FIR tap multipliers.
- Sums a programmable number of complex tap products into one filtered output sample, with valid/ready handshakes on both sides.
- Each addition uses the existing combinational complex adder, FIR_cadd: zero latency, wrap-around arithmetic.

---
 rtl/fir_tap_accum_pkg.sv | 22 ++
 rtl/FIR_cadd.sv | 15 +
 rtl/fir_tap_accum.sv | 174 +++++++++++++++++
 tb/tb_fir_tap_accum.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tap_accum_pkg.sv
// Shared FIR types: complex sample struct, accumulator state enum, tap limits.
// The sample component width comes from `FIR_DATA_WIDTH (default 16).
`ifndef FIR_DATA_WIDTH
`define FIR_DATA_WIDTH 16
`endif

package fir_tap_accum_pkg;

  localparam int FIR_MAX_TAPS = 64;

  typedef struct packed {
    logic signed [`FIR_DATA_WIDTH-1:0] data_r;
    logic signed [`FIR_DATA_WIDTH-1:0] data_i;
  } FIR_DATA_SAMPLE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } fir_acc_state_e;

endpackage

// File: rtl/FIR_cadd.sv
// Combinational complex adder: component-wise two's-complement wrap-around sum.
module FIR_cadd
  import fir_tap_accum_pkg::*;
(
  input  FIR_DATA_SAMPLE a,
  input  FIR_DATA_SAMPLE b,
  output FIR_DATA_SAMPLE sum
);

  always_comb begin
    sum.data_r = a.data_r + b.data_r;
    sum.data_i = a.data_i + b.data_i;
  end

endmodule

// File: rtl/fir_tap_accum.sv
// Complex tap accumulator: sums cfg_tap_num tap products per output sample.
// Optional in_last framing check enabled by defining FIR_TAP_ACCUM_LAST_CHECK_EN.
module fir_tap_accum
  import fir_tap_accum_pkg::*;
#(
  parameter int  DATA_WIDTH = `FIR_DATA_WIDTH,
  parameter int  MAX_TAPS   = FIR_MAX_TAPS,
  localparam int CNT_WIDTH  = $clog2(MAX_TAPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] cfg_tap_num,
  input  FIR_DATA_SAMPLE       in_sample,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output FIR_DATA_SAMPLE       out_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 last_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_TAPS);

  fir_acc_state_e               state_q, state_d;
  logic signed [DATA_WIDTH-1:0] acc_r_q, acc_r_d;
  logic signed [DATA_WIDTH-1:0] acc_i_q, acc_i_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         tap_num_q, tap_num_d;
  FIR_DATA_SAMPLE               out_sample_d;
  logic                         out_valid_d;
  logic                         accept;
  logic                         tap_final;
  FIR_DATA_SAMPLE               acc_sample;
  FIR_DATA_SAMPLE               sum;

  function automatic logic [CNT_WIDTH-1:0] clamp_taps(input logic [CNT_WIDTH-1:0] n);
    if (n == '0) begin
      return CNT_ONE;
    end else if (n > CNT_MAX) begin
      return CNT_MAX;
    end
    return n;
  endfunction

  assign acc_sample.data_r = acc_r_q;
  assign acc_sample.data_i = acc_i_q;

  FIR_cadd u_cadd (
    .a   (acc_sample),
    .b   (in_sample),
    .sum (sum)
  );

  // in_ready depends only on registered state, never on out_ready
  assign in_ready = (state_q != HOLD);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    acc_r_d      = acc_r_q;
    acc_i_d      = acc_i_q;
    cnt_d        = cnt_q;
    tap_num_d    = tap_num_q;
    out_sample_d = out_sample;
    out_valid_d  = out_valid;
    tap_final    = 1'b0;
    accept       = in_valid && (state_q != HOLD);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tap_num_d = clamp_taps(cfg_tap_num);
          acc_r_d   = in_sample.data_r;
          acc_i_d   = in_sample.data_i;
          cnt_d     = CNT_ONE;
          tap_final = (tap_num_d == CNT_ONE);
          if (tap_final) begin
            out_sample_d = in_sample;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d     = cnt_q + CNT_ONE;
          tap_final = (cnt_q == tap_num_q - CNT_ONE);
          if (tap_final) begin
            out_sample_d = sum;
            out_valid_d  = 1'b1;
            acc_r_d      = '0;
            acc_i_d      = '0;
            state_d      = HOLD;
          end else begin
            acc_r_d = sum.data_r;
            acc_i_d = sum.data_i;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any beat or handshake in the same cycle
    if (clr) begin
      state_d     = IDLE;
      acc_r_d     = '0;
      acc_i_d     = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_r_q    <= '0;
      acc_i_q    <= '0;
      cnt_q      <= '0;
      tap_num_q  <= CNT_ONE;
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_r_q    <= acc_r_d;
      acc_i_q    <= acc_i_d;
      cnt_q      <= cnt_d;
      tap_num_q  <= tap_num_d;
      out_sample <= out_sample_d;
      out_valid  <= out_valid_d;
    end
  end

`ifdef FIR_TAP_ACCUM_LAST_CHECK_EN
  logic last_err_q, last_err_d;

  // Framing error is sticky; the count alone still decides group boundaries
  always_comb begin
    last_err_d = last_err_q;
    if (accept && (in_last != tap_final)) begin
      last_err_d = 1'b1;
    end
    if (clr) begin
      last_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_err_q <= 1'b0;
    end else begin
      last_err_q <= last_err_d;
    end
  end

  assign last_err = last_err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_accum.sv
// Directed table-driven bench for fir_tap_accum plus hand sequences for
// stalls, flush, reset mid-group, tap clamping and the in_last check.
module tb_fir_tap_accum;
  import fir_tap_accum_pkg::*;

  localparam int DW = `FIR_DATA_WIDTH;
  localparam int CW = $clog2(FIR_MAX_TAPS + 1);
`ifdef FIR_TAP_ACCUM_LAST_CHECK_EN
  localparam logic LAST_EN = 1'b1;
`else
  localparam logic LAST_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic [CW-1:0]  cfg_tap_num = '0;
  FIR_DATA_SAMPLE in_sample = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           in_last = 1'b0;
  FIR_DATA_SAMPLE out_sample;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           busy;
  logic           last_err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int tap;
    int nb;
    int ir[4];
    int ii[4];
    int er;
    int ei;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  fir_tap_accum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .cfg_tap_num (cfg_tap_num),
    .in_sample   (in_sample),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .last_err    (last_err)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int x);
    logic signed [DW-1:0] t;
    t = x[DW-1:0];
    return int'(t);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int i, input logic v, input logic last);
    in_valid         = v;
    in_sample.data_r = DW'(r);
    in_sample.data_i = DW'(i);
    in_last          = last;
  endtask

  task automatic set_vec(input int k, input int tap, input int nb,
                         input int r0, input int i0, input int r1, input int i1,
                         input int r2, input int i2, input int r3, input int i3,
                         input int er, input int ei);
    vecs[k].tap = tap;  vecs[k].nb = nb;
    vecs[k].ir[0] = r0; vecs[k].ii[0] = i0;
    vecs[k].ir[1] = r1; vecs[k].ii[1] = i1;
    vecs[k].ir[2] = r2; vecs[k].ii[2] = i2;
    vecs[k].ir[3] = r3; vecs[k].ii[3] = i3;
    vecs[k].er = er;    vecs[k].ei = ei;
  endtask

  task automatic run_vec(input int k);
    cfg_tap_num = CW'(vecs[k].tap);
    for (int b = 0; b < vecs[k].nb; b++) begin
      drive(vecs[k].ir[b], vecs[k].ii[b], 1'b1, b == vecs[k].nb - 1);
      check($sformatf("v%0d_ready_b%0d", k, b), int'(in_ready), 1);
      step();
      if (b < vecs[k].nb - 1)
        check($sformatf("v%0d_early_valid_b%0d", k, b), int'(out_valid), 0);
    end
    drive(0, 0, 1'b0, 1'b0);
    check($sformatf("v%0d_valid", k), int'(out_valid), 1);
    check($sformatf("v%0d_out_r", k), int'(out_sample.data_r), wrap(vecs[k].er));
    check($sformatf("v%0d_out_i", k), int'(out_sample.data_i), wrap(vecs[k].ei));
    check($sformatf("v%0d_hold_ready", k), int'(in_ready), 0);
    check($sformatf("v%0d_last_err", k), int'(last_err), 0);
    step();
    check($sformatf("v%0d_valid_drop", k), int'(out_valid), 0);
    check($sformatf("v%0d_idle", k), int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 4, 4, 1, 2, 3, 4, 5, 6, 7, 8, 16, 20);
    set_vec(1, 1, 1, -5, 9, 0, 0, 0, 0, 0, 0, -5, 9);
    set_vec(2, 0, 1, -5, 9, 0, 0, 0, 0, 0, 0, -5, 9);
    set_vec(3, 2, 2, 32767, -32768, 1, -1, 0, 0, 0, 0, -32768, 32767);
    set_vec(4, 3, 3, 100, -100, -50, 25, -60, 80, 0, 0, -10, 5);
    set_vec(5, 2, 2, -1, -1, -1, -1, 0, 0, 0, 0, -2, -2);
    set_vec(6, 2, 2, 2, 3, 4, 5, 0, 0, 0, 0, 6, 8);
    set_vec(7, 4, 4, 1, 1, 1, 1, 1, 1, 1, 1, 4, 4);

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_r", int'(out_sample.data_r), 0);
    check("rst_out_i", int'(out_sample.data_i), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_last_err", int'(last_err), 0);

    for (int k = 0; k < NV; k++) run_vec(k);

    // ACCUM stall, mid-group cfg change, then HOLD backpressure
    cfg_tap_num = CW'(3);
    drive(10, 20, 1'b1, 1'b0);
    step();
    cfg_tap_num = CW'(1);
    drive(0, 0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step();
      check($sformatf("stall_busy_%0d", s), int'(busy), 1);
      check($sformatf("stall_valid_%0d", s), int'(out_valid), 0);
    end
    drive(30, 40, 1'b1, 1'b0);
    step();
    check("cfgchg_no_early_out", int'(out_valid), 0);
    drive(50, 60, 1'b1, 1'b1);
    out_ready = 1'b0;
    step();
    drive(999, 999, 1'b1, 1'b0);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp_valid_%0d", s), int'(out_valid), 1);
      check($sformatf("bp_out_r_%0d", s), int'(out_sample.data_r), 90);
      check($sformatf("bp_out_i_%0d", s), int'(out_sample.data_i), 120);
      check($sformatf("bp_ready_%0d", s), int'(in_ready), 0);
      step();
    end
    drive(0, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    check("bp_release_valid", int'(out_valid), 1);
    step();
    check("bp_done_valid", int'(out_valid), 0);
    check("bp_done_busy", int'(busy), 0);
    run_vec(6);

    // Flush mid-group with a concurrent beat
    cfg_tap_num = CW'(4);
    drive(1, 1, 1'b1, 1'b0);
    step();
    step();
    drive(9, 9, 1'b1, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    check("clr_busy", int'(busy), 0);
    check("clr_valid", int'(out_valid), 0);
    check("clr_ready", int'(in_ready), 1);
    run_vec(7);

    // Flush while a result is pending
    cfg_tap_num = CW'(1);
    out_ready   = 1'b0;
    drive(7, 7, 1'b1, 1'b1);
    step();
    drive(0, 0, 1'b0, 1'b0);
    check("clr_hold_valid_pre", int'(out_valid), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    out_ready = 1'b1;
    check("clr_hold_valid", int'(out_valid), 0);
    check("clr_hold_busy", int'(busy), 0);

    // Reset in the middle of a group
    cfg_tap_num = CW'(3);
    drive(5, 5, 1'b1, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    check("rstmid_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_valid", int'(out_valid), 0);
    check("rstmid_out_r", int'(out_sample.data_r), 0);
    run_vec(4);

    // Tap count above the maximum clamps to 64 beats
    cfg_tap_num = CW'(70);
    for (int b = 0; b < 64; b++) begin
      drive(1, -1, 1'b1, b == 63);
      step();
      if (b == 62) check("clamp_no_early_out", int'(out_valid), 0);
    end
    drive(0, 0, 1'b0, 1'b0);
    check("clamp_valid", int'(out_valid), 1);
    check("clamp_out_r", int'(out_sample.data_r), 64);
    check("clamp_out_i", int'(out_sample.data_i), -64);
    step();
    check("clamp_idle", int'(busy), 0);

    // in_last framing: marked on beat 2 of 3, not on beat 3
    cfg_tap_num = CW'(3);
    drive(1, 1, 1'b1, 1'b0);
    step();
    check("last_beat1_err", int'(last_err), 0);
    drive(2, 2, 1'b1, 1'b1);
    step();
    check("last_beat2_err", int'(last_err), int'(LAST_EN));
    drive(3, 3, 1'b1, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    check("last_sum_valid", int'(out_valid), 1);
    check("last_sum_r", int'(out_sample.data_r), 6);
    check("last_sum_i", int'(out_sample.data_i), 6);
    step();
    check("last_sticky", int'(last_err), int'(LAST_EN));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("last_clr", int'(last_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
